// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and constants (rounding modes, flag bit positions,
// FP32 field layout and the stage-1 record of the FP32 -> integer converter).
package fpu_pkg;

   localparam int FP32_EXP_W   = 8;
   localparam int FP32_MAN_W   = 23;
   localparam int FP32_BIAS    = 127;
   // Biased exponent at which the mantissa LSB carries weight 1 (bias + 23).
   localparam int FP32_INT_EXP = 150;

   // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   // Outcome of the range check: in-range value, or saturate high / low.
   typedef enum logic [1:0] {
      SEL_VAL = 2'd0,
      SEL_MAX = 2'd1,
      SEL_MIN = 2'd2
   } f2i_sel_e;

   // Operand after unpack, classification and alignment.
   typedef struct packed {
      logic        sign;
      logic        nan;
      logic        inf;
      logic        big;   // |x| >= 2^OUT_W, saturates regardless of rounding
      logic [2:0]  rm;
      logic        uns;
      logic [31:0] mag;   // truncated integer magnitude
      logic        g;     // weight 1/2
      logic        r;     // weight 1/4
      logic        s;     // OR of everything below 1/4
   } f2i_s1_t;

endpackage

// File: rtl/fcvt_round.sv
// fcvt_round: increment decision for rounding a truncated magnitude, given
// the rounding mode, the operand sign, the kept LSB and guard/round/sticky.
module fcvt_round
   import fpu_pkg::*;
(
   input  logic [2:0] rm_i,
   input  logic       sign_i,
   input  logic       lsb_i,
   input  logic       g_i,
   input  logic       r_i,
   input  logic       s_i,
   output logic       inc_o
);

   logic inexact_s;

   assign inexact_s = g_i | r_i | s_i;

   // Select the magnitude increment for the requested direction; reserved modes round to nearest even
   always_comb begin
      inc_o = 1'b0;
      case (rm_i)
         RM_RNE:  inc_o = g_i & (lsb_i | r_i | s_i);
         RM_RTZ:  inc_o = 1'b0;
         RM_RDN:  inc_o = sign_i & inexact_s;
         RM_RUP:  inc_o = ~sign_i & inexact_s;
         RM_RMM:  inc_o = g_i;
         default: inc_o = g_i & (lsb_i | r_i | s_i);
      endcase
   end

endmodule

// File: rtl/fcvt_f2i_pipe.sv
// fcvt_f2i_pipe: pipelined FP32 -> signed/unsigned integer converter with
// selectable rounding and ready/valid flow control.
// Optional feature macro: FCVT_FLAGS_EN (adds the out_flags port and flag logic).
module fcvt_f2i_pipe
   import fpu_pkg::*;
#(
   parameter int OUT_W  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      in_f,
   input  logic [2:0]       rm,
   input  logic             is_unsigned,
   input  logic             input_valid,
   output logic             input_ready,
   output logic [OUT_W-1:0] out_i,
`ifdef FCVT_FLAGS_EN
   output logic [4:0]       out_flags,
`endif
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [8:0]       BIG_EXP = 9'(FP32_BIAS + OUT_W);
   localparam logic [OUT_W-1:0] SMAX    = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SMIN    = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] UMAX    = {OUT_W{1'b1}};

   logic             advance_s;
   logic             last_v_s;
   logic [7:0]       exp_s;
   logic [23:0]      sig_s;
   logic [8:0]       rsh_s;
   logic [4:0]       lsh_s;
   logic [55:0]      shr_s;
   f2i_s1_t          s1_d, s1_q;
   logic             v1_q, v2_q;
   logic             inc_s;
   logic [32:0]      mag_r_s;
   logic             ovf_u_s, ovf_sp_s, ovf_sn_s;
   f2i_sel_e         sel_s;
   logic [OUT_W-1:0] res_s, r2_q;

   // Whole pipe moves together whenever the last stage can hand off.
   assign advance_s   = ~last_v_s | out_ready;
   assign input_ready = advance_s;

   assign exp_s = in_f[30:23];
   assign sig_s = {(exp_s != 8'd0), in_f[22:0]};
   assign rsh_s = 9'(FP32_INT_EXP) - {1'b0, exp_s};
   // exp - 150 modulo 32 (150 mod 32 = 22); only used for exp in 150..158.
   assign lsh_s = exp_s[4:0] - 5'd22;
   assign shr_s = {sig_s, 32'd0} >> rsh_s[4:0];

   // Stage 1 logic: classify and align {hidden,mant} into integer magnitude plus g/r/s
   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_f[31];
      s1_d.nan  = (exp_s == 8'hFF) & (in_f[22:0] != 23'd0);
      s1_d.inf  = (exp_s == 8'hFF) & (in_f[22:0] == 23'd0);
      s1_d.big  = ({1'b0, exp_s} >= BIG_EXP);
      s1_d.rm   = rm;
      s1_d.uns  = is_unsigned;
      if ({1'b0, exp_s} >= 9'(FP32_INT_EXP)) begin
         s1_d.mag = {8'd0, sig_s} << lsh_s;
      end else if (rsh_s >= 9'd32) begin
         // |x| < 1/4 (or zero/denormal): only the sticky survives
         s1_d.s = (sig_s != 24'd0);
      end else begin
         s1_d.mag = {8'd0, shr_s[55:32]};
         s1_d.g   = shr_s[31];
         s1_d.r   = shr_s[30];
         s1_d.s   = |shr_s[29:0];
      end
   end

   // Stage 1 register: aligned operand, held while the pipe is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         s1_q <= '0;
      end else if (advance_s) begin
         v1_q <= input_valid;
         s1_q <= s1_d;
      end
   end

   fcvt_round u_round (
      .rm_i   (s1_q.rm),
      .sign_i (s1_q.sign),
      .lsb_i  (s1_q.mag[0]),
      .g_i    (s1_q.g),
      .r_i    (s1_q.r),
      .s_i    (s1_q.s),
      .inc_o  (inc_s)
   );

   assign mag_r_s  = {1'b0, s1_q.mag} + {32'd0, inc_s};
   assign ovf_u_s  = |mag_r_s[32:OUT_W];
   assign ovf_sp_s = |mag_r_s[32:OUT_W-1];
   // Negative side admits exactly 2^(OUT_W-1)
   assign ovf_sn_s = ovf_u_s | (mag_r_s[OUT_W-1] & (|mag_r_s[OUT_W-2:0]));

   // Range check of the rounded magnitude
   always_comb begin
      sel_s = SEL_VAL;
      if (s1_q.nan) begin
         sel_s = SEL_MAX;
      end else if (s1_q.inf || s1_q.big) begin
         sel_s = s1_q.sign ? SEL_MIN : SEL_MAX;
      end else if (s1_q.uns) begin
         if (s1_q.sign) sel_s = (mag_r_s != 33'd0) ? SEL_MIN : SEL_VAL;
         else           sel_s = ovf_u_s ? SEL_MAX : SEL_VAL;
      end else begin
         if (s1_q.sign) sel_s = ovf_sn_s ? SEL_MIN : SEL_VAL;
         else           sel_s = ovf_sp_s ? SEL_MAX : SEL_VAL;
      end
   end

   // Result: negate in-range negatives, otherwise pick the saturation bound
   always_comb begin
      res_s = {OUT_W{1'b0}};
      case (sel_s)
         SEL_VAL: begin
            if (s1_q.sign) res_s = ~mag_r_s[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1};
            else           res_s = mag_r_s[OUT_W-1:0];
         end
         SEL_MAX: begin
            if (s1_q.uns) res_s = UMAX;
            else          res_s = SMAX;
         end
         SEL_MIN: begin
            if (s1_q.uns) res_s = {OUT_W{1'b0}};
            else          res_s = SMIN;
         end
         default: res_s = {OUT_W{1'b0}};
      endcase
   end

   // Stage 2 register: converted result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q <= 1'b0;
         r2_q <= {OUT_W{1'b0}};
      end else if (advance_s) begin
         v2_q <= v1_q;
         r2_q <= res_s;
      end
   end

`ifdef FCVT_FLAGS_EN
   logic [4:0] flags_s, f2_q;

   // Flags: NV for any saturation/NaN, otherwise NX when bits were discarded
   always_comb begin
      flags_s = 5'd0;
      if (sel_s != SEL_VAL) flags_s[FLAG_NV] = 1'b1;
      else                  flags_s[FLAG_NX] = s1_q.g | s1_q.r | s1_q.s;
   end

   // Stage 2 flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         f2_q <= 5'd0;
      else if (advance_s) f2_q <= flags_s;
   end
`endif

   generate
      if (STAGES == 3) begin : g_s3
         logic             v3_q;
         logic [OUT_W-1:0] r3_q;

         // Stage 3 register: plain copy of the stage-2 result
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v3_q <= 1'b0;
               r3_q <= {OUT_W{1'b0}};
            end else if (advance_s) begin
               v3_q <= v2_q;
               r3_q <= r2_q;
            end
         end
         assign last_v_s = v3_q;
         assign out_i    = r3_q;
`ifdef FCVT_FLAGS_EN
         logic [4:0] f3_q;

         // Stage 3 flag register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         f3_q <= 5'd0;
            else if (advance_s) f3_q <= f2_q;
         end
         assign out_flags = f3_q;
`endif
      end else begin : g_s2
         assign last_v_s = v2_q;
         assign out_i    = r2_q;
`ifdef FCVT_FLAGS_EN
         assign out_flags = f2_q;
`endif
      end
   endgenerate

   assign out_valid = last_v_s;

endmodule
